// File: rtl/baud_pkg.sv
// Shared definitions for the baud tick generator: rate-select encoding,
// preset baud rates and the divisor calculation used to build the preset table.
package baud_pkg;

   typedef enum logic [2:0] {
      SEL_2400   = 3'd0,
      SEL_4800   = 3'd1,
      SEL_9600   = 3'd2,
      SEL_19200  = 3'd3,
      SEL_38400  = 3'd4,
      SEL_57600  = 3'd5,
      SEL_115200 = 3'd6,
      SEL_CUSTOM = 3'd7
   } baud_sel_e;

   localparam int unsigned BAUD_2400   = 2400;
   localparam int unsigned BAUD_4800   = 4800;
   localparam int unsigned BAUD_9600   = 9600;
   localparam int unsigned BAUD_19200  = 19200;
   localparam int unsigned BAUD_38400  = 38400;
   localparam int unsigned BAUD_57600  = 57600;
   localparam int unsigned BAUD_115200 = 115200;

   typedef struct packed {
      logic [31:0] n;
      logic [31:0] f;
   } div_pair_t;

   function automatic int unsigned preset_baud(input int idx);
      case (idx)
         0:       return BAUD_2400;
         1:       return BAUD_4800;
         2:       return BAUD_9600;
         3:       return BAUD_19200;
         4:       return BAUD_38400;
         5:       return BAUD_57600;
         default: return BAUD_115200;
      endcase
   endfunction

   // Divisor in units of 2^-frac_w clocks per oversample tick, rounded to nearest.
   function automatic div_pair_t calc_div(input longint unsigned clk_hz,
                                          input longint unsigned baud,
                                          input int unsigned     ovs,
                                          input int unsigned     frac_w);
      longint unsigned den;
      longint unsigned q;
      div_pair_t       r;
      den = baud * ovs;
      q   = ((clk_hz << frac_w) + den / 2) / den;
      r.n = 32'(q >> frac_w);
      r.f = 32'(q & ((64'd1 << frac_w) - 64'd1));
      return r;
   endfunction

endpackage

// File: rtl/baud_tick_gen_frac_divider.sv
// Fractional-N down-counter: each oversample period lasts Na clocks, or Na+1
// when the fractional accumulator carries, giving a mean of Na + Fa/2^FRAC_W.
module frac_divider #(
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned FRAC_W = 4
) (
   input  logic              clock_i,
   input  logic              rst_n_i,
   input  logic              en_i,
   input  logic [CNT_W-1:0]  na_i,
   input  logic [FRAC_W-1:0] fa_i,
   output logic              boundary_o,
   output logic              start_o
);

   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_eff;
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic              run_q, run_d;
   logic [FRAC_W:0]   sum;
   logic [CNT_W:0]    period;

   // On the first enabled cycle the count behaves as if preloaded with Na-1,
   // so the first tick lands exactly Na cycles after enable, even out of reset.
   assign cnt_eff    = run_q ? cnt_q : (na_i - 1'b1);
   assign boundary_o = en_i && (cnt_eff == '0);
   assign start_o    = en_i && !run_q;
   assign sum        = {1'b0, acc_q} + {1'b0, fa_i};
   assign period     = {1'b0, na_i} + {{CNT_W{1'b0}}, sum[FRAC_W]};

   always_comb begin
      cnt_d = cnt_q;
      acc_d = acc_q;
      run_d = run_q;
      if (!en_i) begin
         cnt_d = na_i - 1'b1;
         acc_d = '0;
         run_d = 1'b0;
      end else begin
         run_d = 1'b1;
         if (boundary_o) begin
            cnt_d = CNT_W'(period - 1'b1);
            acc_d = sum[FRAC_W-1:0];
         end else begin
            cnt_d = cnt_eff - 1'b1;
         end
      end
   end

   always_ff @(posedge clock_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
         acc_q <= '0;
         run_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         acc_q <= acc_d;
         run_q <= run_d;
      end
   end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud-rate tick generator: selects a preset or custom divisor, drives the
// fractional divider and derives oversample ticks, bit ticks and a baud clock.
module baud_tick_gen
   import baud_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned OVS    = 16,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned FRAC_W = 4
) (
   input  logic              clock_i,
   input  logic              rst_n_i,
   input  logic              en_i,
   input  logic [2:0]        baud_sel_i,
   input  logic [CNT_W-1:0]  div_int_i,
   input  logic [FRAC_W-1:0] div_frac_i,
   output logic              tick_ovs_o,
   output logic              tick_bit_o,
   output logic              baud_clk_o,
   output logic              div_upd_o
);

   localparam int unsigned       OVS_W   = $clog2(OVS);
   localparam logic [OVS_W-1:0]  LAST    = OVS_W'(OVS - 1);
   localparam logic [OVS_W-1:0]  HALF_M1 = OVS_W'(OVS / 2 - 1);

   logic [CNT_W-1:0]  src_n [8];
   logic [FRAC_W-1:0] src_f [8];
   logic [CNT_W-1:0]  na_sel, na_d, na_q;
   logic [FRAC_W-1:0] fa_sel, fa_d, fa_q;
   logic              sample, boundary, start, upd_d;
   logic [OVS_W-1:0]  ovs_q, ovs_d;
   logic              baud_q, baud_d;
   logic              tick_ovs_q, tick_bit_q, div_upd_q;

   for (genvar g = 0; g < 8; g++) begin : g_src
      if (g == int'(SEL_CUSTOM)) begin : g_custom
         assign src_n[g] = (div_int_i == '0) ? CNT_W'(1) : div_int_i;
         assign src_f[g] = div_frac_i;
      end else begin : g_preset
         localparam div_pair_t DIV = calc_div(64'(CLK_HZ), 64'(preset_baud(g)), OVS, FRAC_W);
         assign src_n[g] = DIV.n[CNT_W-1:0];
         assign src_f[g] = DIV.f[FRAC_W-1:0];
      end
   end

   assign na_sel = src_n[baud_sel_i];
   assign fa_sel = src_f[baud_sel_i];

   // Source changes only land at a period boundary or while idle.
   assign sample = !en_i || start || boundary;
   assign na_d   = sample ? na_sel : na_q;
   assign fa_d   = sample ? fa_sel : fa_q;
   assign upd_d  = sample && ((na_sel != na_q) || (fa_sel != fa_q));

   frac_divider #(
      .CNT_W (CNT_W),
      .FRAC_W(FRAC_W)
   ) u_frac_divider (
      .clock_i   (clock_i),
      .rst_n_i   (rst_n_i),
      .en_i      (en_i),
      .na_i      (na_d),
      .fa_i      (fa_d),
      .boundary_o(boundary),
      .start_o   (start)
   );

   always_comb begin
      ovs_d  = ovs_q;
      baud_d = baud_q;
      if (!en_i) begin
         ovs_d  = '0;
         baud_d = 1'b0;
      end else if (boundary) begin
         ovs_d = ovs_q + 1'b1;
         if (ovs_q == HALF_M1) begin
            baud_d = 1'b1;
         end else if (ovs_q == LAST) begin
            baud_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         na_q       <= CNT_W'(1);
         fa_q       <= '0;
         ovs_q      <= '0;
         baud_q     <= 1'b0;
         tick_ovs_q <= 1'b0;
         tick_bit_q <= 1'b0;
         div_upd_q  <= 1'b0;
      end else begin
         na_q       <= na_d;
         fa_q       <= fa_d;
         ovs_q      <= ovs_d;
         baud_q     <= baud_d;
         tick_ovs_q <= boundary;
         tick_bit_q <= boundary && (ovs_q == LAST);
         div_upd_q  <= upd_d;
      end
   end

   assign tick_ovs_o = tick_ovs_q;
   assign tick_bit_o = tick_bit_q;
   assign baud_clk_o = baud_q;
   assign div_upd_o  = div_upd_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: an event-time reference model checks every output
// each cycle, plus directed interval measurements for the key cadences.
module tb_baud_tick_gen;

   localparam longint CLK_HZ   = 50_000_000;
   localparam int     OVS      = 16;
   localparam int     CNT_W    = 16;
   localparam int     FRAC_W   = 4;
   localparam int     FRAC_ONE = 1 << FRAC_W;

   logic              clock = 1'b0;
   logic              rst_n;
   logic              en;
   logic [2:0]        baud_sel;
   logic [CNT_W-1:0]  div_int;
   logic [FRAC_W-1:0] div_frac;
   logic              tick_ovs, tick_bit, baud_clk, div_upd;

   int     n_cmp = 0;
   int     n_bad = 0;
   longint cyc = 0;
   int     rates [7] = '{2400, 4800, 9600, 19200, 38400, 57600, 115200};

   longint tick_q[$], bit_q[$], rise_q[$], fall_q[$];
   int     upd_cnt = 0;
   logic   baud_prev = 1'b0;
   longint t_en;
   int     upd0;

   // reference model state: active divisor, accumulator, tick count, next boundary edge
   int     m_na, m_fa, m_acc, m_ticks;
   bit     m_run;
   longint m_p = 0;
   longint m_bnd;
   bit     e_tick, e_bit, e_baud, e_upd;

   baud_tick_gen #(
      .CLK_HZ(50_000_000),
      .OVS   (OVS),
      .CNT_W (CNT_W),
      .FRAC_W(FRAC_W)
   ) dut (
      .clock_i   (clock),
      .rst_n_i   (rst_n),
      .en_i      (en),
      .baud_sel_i(baud_sel),
      .div_int_i (div_int),
      .div_frac_i(div_frac),
      .tick_ovs_o(tick_ovs),
      .tick_bit_o(tick_bit),
      .baud_clk_o(baud_clk),
      .div_upd_o (div_upd)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic ref_divisor(input logic [2:0] sel, input logic [CNT_W-1:0] n_in,
                              input logic [FRAC_W-1:0] f_in, output int n, output int f);
      longint q, b;
      if (sel == 3'd7) begin
         n = (n_in == 0) ? 1 : int'(n_in);
         f = int'(f_in);
      end else begin
         b = longint'(rates[sel]);
         q = (CLK_HZ * FRAC_ONE + (b * OVS) / 2) / (b * OVS);
         n = int'(q / FRAC_ONE);
         f = int'(q % FRAC_ONE);
      end
   endtask

   task automatic model_reset();
      m_na = 1; m_fa = 0; m_acc = 0; m_ticks = 0; m_run = 0; m_bnd = 0;
      e_tick = 0; e_bit = 0; e_baud = 0; e_upd = 0;
   endtask

   task automatic model_step();
      int sn, sf, sum;
      bit sample;
      m_p++;
      ref_divisor(baud_sel, div_int, div_frac, sn, sf);
      e_tick = 0; e_bit = 0; e_upd = 0; sample = 0;
      if (!en) begin
         m_run = 0; m_acc = 0; m_ticks = 0; e_baud = 0; sample = 1;
      end else if (!m_run) begin
         m_run = 1; m_bnd = m_p + sn - 1; sample = 1;
      end
      if (en && m_p == m_bnd) begin
         sample  = 1;
         sum     = m_acc + sf;
         m_acc   = sum % FRAC_ONE;
         m_bnd   = m_p + sn + ((sum >= FRAC_ONE) ? 1 : 0);
         m_ticks++;
         e_tick  = 1;
         e_bit   = (m_ticks % OVS) == 0;
         e_baud  = (m_ticks % OVS) >= OVS / 2;
      end
      if (sample) begin
         e_upd = (sn != m_na) || (sf != m_fa);
         m_na  = sn;
         m_fa  = sf;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clock or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   initial forever begin
      @(negedge clock);
      check("tick_ovs", tick_ovs, e_tick);
      check("tick_bit", tick_bit, e_bit);
      check("baud_clk", baud_clk, e_baud);
      check("div_upd", div_upd, e_upd);
      if (tick_ovs) tick_q.push_back(cyc);
      if (tick_bit) bit_q.push_back(cyc);
      if (baud_clk && !baud_prev) rise_q.push_back(cyc);
      if (!baud_clk && baud_prev) fall_q.push_back(cyc);
      baud_prev = baud_clk;
      if (div_upd) upd_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic clear_q();
      tick_q.delete(); bit_q.delete(); rise_q.delete(); fall_q.delete();
      upd_cnt = 0;
   endtask

   task automatic wait_ticks(input string tag, input int n, input int budget);
      int k = 0;
      while (tick_q.size() < n && k < budget) begin
         step(1);
         k++;
      end
      check(tag, tick_q.size() >= n, 1);
   endtask

   task automatic randomize_src();
      case ($urandom_range(0, 3))
         0:       baud_sel = 3'd5;
         1:       baud_sel = 3'd6;
         default: baud_sel = 3'd7;
      endcase
      div_int  = CNT_W'($urandom_range(0, 9));
      div_frac = FRAC_W'($urandom);
   endtask

   initial begin
      int k;
      int len;
      rst_n = 1'b0; en = 1'b0; baud_sel = 3'd7; div_int = 16'd4; div_frac = '0;
      step(3);
      check("rst_tick_ovs", tick_ovs, 0);
      check("rst_tick_bit", tick_bit, 0);
      check("rst_baud_clk", baud_clk, 0);
      check("rst_div_upd", div_upd, 0);
      rst_n = 1'b1;
      step(2);

      // custom N=4 F=0 cadence
      clear_q();
      en = 1'b1; t_en = cyc;
      step(200);
      check("cust_first_tick", tick_q[0] - t_en, 4);
      check("cust_tick_iv", tick_q[1] - tick_q[0], 4);
      check("cust_tick_iv_late", tick_q[20] - tick_q[19], 4);
      check("cust_first_bit", bit_q[0] - t_en, 64);
      check("cust_bit_period", bit_q[1] - bit_q[0], 64);
      check("cust_baud_high", fall_q[0] - rise_q[0], 32);
      check("cust_baud_period", rise_q[1] - rise_q[0], 64);

      // fractional N=4 F=8
      en = 1'b0; step(1);
      div_frac = 4'd8; step(1);
      clear_q();
      en = 1'b1; t_en = cyc;
      wait_ticks("frac_wait", 32, 400);
      check("frac_iv_a", tick_q[1] - tick_q[0], 4);
      check("frac_iv_b", tick_q[2] - tick_q[1], 5);
      check("frac_iv_pair", tick_q[20] - tick_q[18], 9);
      // cycles from the first enabled cycle through the 32nd tick, inclusive
      check("frac_32_ticks", tick_q[31] - t_en + 1, 144);

      // mid-period divisor change 10 -> 6
      en = 1'b0; div_int = 16'd10; div_frac = '0; step(1);
      clear_q();
      en = 1'b1;
      wait_ticks("chg_wait_a", 2, 100);
      step(1);
      div_int = 16'd6; upd0 = upd_cnt;
      wait_ticks("chg_wait_b", 5, 100);
      check("chg_iv_kept", tick_q[2] - tick_q[1], 10);
      check("chg_iv_new", tick_q[3] - tick_q[2], 6);
      check("chg_iv_new2", tick_q[4] - tick_q[3], 6);
      check("chg_upd_once", upd_cnt - upd0, 1);

      // en dropped mid-bit for 5 cycles
      en = 1'b0; div_int = 16'd4; step(1);
      en = 1'b1; clear_q();
      wait_ticks("en_wait_a", 20, 200);
      en = 1'b0; step(1);
      clear_q(); step(4);
      check("en_low_ticks", tick_q.size(), 0);
      check("en_low_baud", baud_clk, 0);
      clear_q();
      en = 1'b1; t_en = cyc;
      wait_ticks("en_wait_b", 16, 200);
      check("reen_first_tick", tick_q[0] - t_en, 4);
      check("reen_bit_count", bit_q.size(), 1);
      check("reen_bit_at_16", bit_q[0], tick_q[15]);

      // reset pulsed while baud_clk is high
      k = 0;
      while (!baud_clk && k < 100) begin
         step(1);
         k++;
      end
      check("rst_wait_baud", baud_clk, 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_tick_ovs", tick_ovs, 0);
      check("rst_mid_tick_bit", tick_bit, 0);
      check("rst_mid_baud_clk", baud_clk, 0);
      check("rst_mid_div_upd", div_upd, 0);
      step(2);
      rst_n = 1'b1; clear_q(); t_en = cyc;
      wait_ticks("rst_restart", 2, 50);
      check("rst_first_tick", tick_q[0] - t_en, 4);
      check("rst_upd", upd_cnt, 1);

      // preset 9600 at 50 MHz
      en = 1'b0; baud_sel = 3'd2; step(1);
      clear_q();
      en = 1'b1; t_en = cyc;
      k = 0;
      while (bit_q.size() < 11 && k < 60000) begin
         step(1);
         k++;
      end
      check("pre_bit_wait", bit_q.size() >= 11, 1);
      check("pre_first_tick", tick_q[0] - t_en, 325);
      check("pre_iv_a", tick_q[1] - tick_q[0], 325);
      check("pre_iv_b", tick_q[2] - tick_q[1], 326);
      check("pre_10_bits", bit_q[10] - bit_q[0], 52080);

      // randomized source, enable and reset activity against the model
      randomize_src();
      en = 1'b1;
      for (int s = 0; s < 40; s++) begin
         len = $urandom_range(5, 120);
         case ($urandom_range(0, 9))
            0: begin
               rst_n = 1'b0;
               step(1 + $urandom_range(0, 1));
               rst_n = 1'b1;
            end
            1, 2: en = ~en;
            default: en = 1'b1;
         endcase
         for (int c = 0; c < len; c++) begin
            if ($urandom_range(0, 24) == 0) randomize_src();
            step(1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter OVS, default 16, oversample ticks per bit; power of two, 4..64.
REQ-003 Parameter CNT_W, default 16, integer-divisor width.
REQ-004 Parameter FRAC_W, default 4, fractional-divisor width.
REQ-005 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-006 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port en  input  1  run enable; low holds generator idle.
REQ-008 Port baud_sel  input  3  rate select: 0=2400, 1=4800, 2=9600, 3=19200, 4=38400, 5=57600, 6=115200, 7=custom.
REQ-009 Port div_int  input  CNT_W  custom integer divisor N (clocks per oversample tick), used when baud_sel=7.
REQ-010 Port div_frac  input  FRAC_W  custom fractional divisor F (units of 2^-FRAC_W), used when baud_sel=7.
REQ-011 Port tick_ovs  output  1  one-cycle pulse at OVS x baud.
REQ-012 Port tick_bit  output  1  one-cycle pulse at baud, coincident with every OVS-th tick_ovs.
REQ-013 Port baud_clk  output  1  ~50 % duty square wave at baud.
REQ-014 Port div_upd  output  1  one-cycle pulse when a new active divisor takes effect.

Function
REQ-015 Active divisor (Na, Fa) SHALL be registered; for presets Na/Fa come from the package table, for sel=7 from div_int/div_frac, with N=0 treated as N=1.
REQ-016 Oversample period SHALL be Na clocks, or Na+1 clocks when the fractional accumulator carries: acc_next = acc + Fa mod 2^FRAC_W, carry when acc + Fa >= 2^FRAC_W; mean period = Na + Fa/2^FRAC_W.
REQ-017 Down-counter SHALL load period-1 at each boundary and decrement each enabled cycle; boundary = count 0 with en high.
REQ-018 tick_ovs SHALL be registered, high in the cycle after a boundary; first tick_ovs SHALL occur exactly Na cycles after the first cycle en is sampled high (Fa has no effect on the first period).
REQ-019 An ovs counter 0..OVS-1 SHALL advance on each boundary and wrap; tick_bit SHALL pulse with the tick_ovs generated when the counter wraps OVS-1 -> 0.
REQ-020 baud_clk SHALL toggle on the boundaries at which the ovs counter leaves OVS/2-1 (rising) and OVS-1 (falling).
REQ-021 Source selection (baud_sel, div_int, div_frac) SHALL be sampled into the active registers only at a boundary or while en is low; mid-period changes SHALL NOT alter the current period; div_upd SHALL pulse in the cycle after the active values change.
REQ-022 Divisor updates SHALL NOT clear the accumulator or the ovs counter.
REQ-023 en low SHALL synchronously clear the accumulator, ovs counter, tick_ovs, tick_bit and baud_clk and preload the down-counter with Na-1.
REQ-024 Arithmetic SHALL be unsigned; Na+1 SHALL be computed at CNT_W+1 bits so that N = 2^CNT_W-1 does not wrap.

Reset
REQ-025 rst_n low SHALL immediately force tick_ovs=0, tick_bit=0, baud_clk=0, div_upd=0, accumulator=0, ovs counter=0, down-counter=0, Na=1, Fa=0.
REQ-026 After rst_n deasserts with en high, the first cycle SHALL load the active divisor (div_upd=1) and begin counting.
REQ-027 rst_n assertion mid-period SHALL abandon the period with no residual pulse.

Structure
REQ-028 Package baud_pkg SHALL hold the 8-entry baud_sel encoding, the preset baud-rate constants, and a constant function returning {N, F} = round(CLK_HZ*2^FRAC_W/(baud*OVS)) split into integer and fraction parts.
REQ-029 The down-counter plus fractional accumulator SHALL be one sub-module, frac_divider; baud_tick_gen adds source selection, the ovs counter and the output pulses.

Verification
REQ-030 Custom mode: sel=7, N=4, F=0, en high -> tick_ovs every 4 cycles, tick_bit every 64 cycles, baud_clk period 64 cycles with 32 cycles high.
REQ-031 Fractional mode: sel=7, N=4, F=8 -> tick_ovs intervals alternate 4,5,4,5; 32 ticks in exactly 144 cycles.
REQ-032 Preset mode: CLK_HZ=50e6, sel=2 -> Na=325, Fa=8; 10 tick_bit periods total exactly 52080 cycles.
REQ-033 Mid-period change: N=10 -> 6 written 3 cycles after a boundary -> that interval stays 10, div_upd pulses once, following intervals are 6.
REQ-034 en dropped mid-bit, raised 5 cycles later -> outputs 0 while low; first tick_ovs exactly Na cycles after re-enable; tick_bit after 16 further tick_ovs.
REQ-035 rst_n pulsed low while baud_clk=1 -> all outputs 0 in the same cycle; normal cadence restarts per REQ-026.
